sample_window8: RTL

- Upstream feeder for the 8-input averaging datapath.
- Accepts a serial stream of signed 16-bit samples under a valid/ready handshake and keeps the 8 most recent accepted samples.
- Presents those samples in parallel on a..h, together with the fixed shift amount sa.
- Pulses win_valid once per completed window, in sliding mode (STRIDE=1) or in decimated/block mode (STRIDE up to 8).

---
 rtl/sample_window8.sv | 118 +++++++++++
 1 files changed

// File: rtl/sample_window8.sv
// Eight-tap sliding/decimating sample window feeding the averager; taps and win_valid are registered (visible one cycle after the accept).
// in_ready is combinational: low during rst, hold or flush; an accept (in_valid & in_ready) is the only event that moves data.
module sample_window8 #(
   parameter int DATAWIDTH = 16,
   parameter int STRIDE    = 1,
   parameter int SA_VAL    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [DATAWIDTH-1:0] in_data,
   output logic                 in_ready,
   input  logic                 hold,
   input  logic                 flush,
   output logic [DATAWIDTH-1:0] a,
   output logic [DATAWIDTH-1:0] b,
   output logic [DATAWIDTH-1:0] c,
   output logic [DATAWIDTH-1:0] d,
   output logic [DATAWIDTH-1:0] e,
   output logic [DATAWIDTH-1:0] f,
   output logic [DATAWIDTH-1:0] g,
   output logic [DATAWIDTH-1:0] h,
   output logic [7:0]           sa,
   output logic                 win_valid,
   output logic [3:0]           fill_cnt
);

   // Out-of-range strides degrade to sliding mode rather than stalling the pipe.
   localparam int STRIDE_EFF = ((STRIDE < 1) || (STRIDE > 8)) ? 1 : STRIDE;
   localparam logic [2:0] STRIDE_LAST = 3'(STRIDE_EFF - 1);

   if ((STRIDE < 1) || (STRIDE > 8)) begin : g_bad_stride
      $error("sample_window8: STRIDE=%0d out of range 1..8, using 1", STRIDE);
   end

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_t;

   state_t               state, state_nxt;
   logic [3:0]           fill_nxt;
   logic [2:0]           stride_cnt, stride_nxt;
   logic                 win_nxt;
   logic                 accept;
   logic [DATAWIDTH-1:0] tap [8];

   assign sa       = 8'(SA_VAL);
   assign in_ready = ~rst & ~hold & ~flush;
   assign accept   = in_valid & in_ready;

   assign a = tap[0];
   assign b = tap[1];
   assign c = tap[2];
   assign d = tap[3];
   assign e = tap[4];
   assign f = tap[5];
   assign g = tap[6];
   assign h = tap[7];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= FILL;
         fill_cnt   <= 4'd0;
         stride_cnt <= 3'd0;
         win_valid  <= 1'b0;
         for (int i = 0; i < 8; i++) tap[i] <= '0;
      end else begin
         state      <= state_nxt;
         fill_cnt   <= fill_nxt;
         stride_cnt <= stride_nxt;
         win_valid  <= win_nxt;
         // Zeroing on flush keeps a refilling window from mixing in stale samples.
         if (flush) begin
            for (int i = 0; i < 8; i++) tap[i] <= '0;
         end else if (accept) begin
            for (int i = 0; i < 7; i++) tap[i] <= tap[i+1];
            tap[7] <= in_data;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      fill_nxt   = fill_cnt;
      stride_nxt = stride_cnt;
      win_nxt    = 1'b0;
      if (flush) begin
         state_nxt  = FILL;
         fill_nxt   = 4'd0;
         stride_nxt = 3'd0;
      end else if (accept) begin
         case (state)
            FILL: begin
               fill_nxt = fill_cnt + 4'd1;
               if (fill_cnt == 4'd7) begin
                  state_nxt  = FULL;
                  stride_nxt = 3'd0;
                  win_nxt    = 1'b1;
               end
            end
            FULL: begin
               if (stride_cnt == STRIDE_LAST) begin
                  stride_nxt = 3'd0;
                  win_nxt    = 1'b1;
               end else begin
                  stride_nxt = stride_cnt + 3'd1;
               end
            end
            default: begin
               state_nxt = FILL;
               fill_nxt  = 4'd0;
            end
         endcase
      end
   end

endmodule
